// File: rtl/sprite_rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sprite_rom_arbiter
// Description : Shares one sprite/logo ROM between two pixel fetchers.
//               Requester 0 is the player sprite and requester 1 is the ghost
//               sprite. The block grants whole bursts using round-robin
//               arbitration and issues one ROM read per cycle. Returned words
//               go back to the owning requester, tagged with a valid strobe
//               and a last-word strobe.
// Ports       : vga_clk            pixel clock (single clock domain)
//               rst                synchronous reset, active high
//               req[1:0]           burst request (bit0 player, bit1 ghost)
//               req_addr0/1        burst start address per requester
//               req_len0/1         burst length minus one per requester
//               gnt[1:0]           one-cycle grant pulse, one-hot or zero
//               busy               high while a burst is issuing reads
//               rom_en/rom_addr    ROM read strobe and address
//               rom_data           ROM read data, ROM_LAT cycles after rom_en
//               rd_valid[1:0]      returned word valid, tagged by owner
//               rd_last            final word of a burst (qualified by rd_valid)
//               rd_data            returned word, held while rd_valid is zero
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_rom_arbiter #(
    parameter int ADDR_W  = 14,
    parameter int DATA_W  = 16,
    parameter int LEN_W   = 7,
    parameter int ROM_LAT = 1
) (
    input  logic              vga_clk,
    input  logic              rst,
    input  logic [1:0]        req,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic [ADDR_W-1:0] req_addr1,
    input  logic [LEN_W-1:0]  req_len0,
    input  logic [LEN_W-1:0]  req_len1,
    output logic [1:0]        gnt,
    output logic              busy,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [1:0]        rd_valid,
    output logic              rd_last,
    output logic [DATA_W-1:0] rd_data
);

    localparam logic [0:0]        c_ST_IDLE  = 1'b0;
    localparam logic [0:0]        c_ST_BURST = 1'b1;
    localparam logic [ADDR_W-1:0] c_ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0]  c_LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    logic              r_last;      // id of the most recently granted requester
    logic              r_id;        // owner of the burst in progress
    logic              r_first;     // first cycle of the burst (grant cycle)
    logic [ADDR_W-1:0] r_addr;      // address of the read issued this cycle
    logic [LEN_W-1:0]  r_cnt;       // reads remaining after this one

    logic              w_win_id;
    logic              w_start;
    logic              w_in_burst;
    logic              w_burst_last;

    // Return pipeline, one bit per stage; stage ROM_LAT-1 lines up with rom_data.
    logic [ROM_LAT-1:0] r_pv;
    logic [ROM_LAT-1:0] r_pid;
    logic [ROM_LAT-1:0] r_plast;
    logic [DATA_W-1:0]  r_rd_hold;

    // ------------------------------------------------------------------------
    // Winner selection and FSM next state
    // ------------------------------------------------------------------------
    always_comb begin
        w_win_id     = 1'b0;
        w_in_burst   = (r_state == c_ST_BURST);
        w_start      = (r_state == c_ST_IDLE) && (req != 2'b00);
        w_burst_last = w_in_burst && (r_cnt == '0);
        w_state_nxt  = r_state;

        // On a tie the requester that did not win last time goes next.
        if (req == 2'b11) begin
            w_win_id = ~r_last;
        end else if (req[1]) begin
            w_win_id = 1'b1;
        end

        case (r_state)
            c_ST_IDLE: begin
                if (w_start) begin
                    w_state_nxt = c_ST_BURST;
                end
            end
            c_ST_BURST: begin
                if (w_burst_last) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Burst bookkeeping
    // ------------------------------------------------------------------------
    always_ff @(posedge vga_clk) begin
        if (rst) begin
            r_last  <= 1'b1;
            r_id    <= 1'b0;
            r_first <= 1'b0;
            r_addr  <= '0;
            r_cnt   <= '0;
        end else if (w_start) begin
            r_last  <= w_win_id;
            r_id    <= w_win_id;
            r_first <= 1'b1;
            r_addr  <= w_win_id ? req_addr1 : req_addr0;
            r_cnt   <= w_win_id ? req_len1  : req_len0;
        end else if (w_in_burst) begin
            r_first <= 1'b0;
            r_addr  <= r_addr + c_ADDR_ONE;   // wraps modulo 2^ADDR_W
            r_cnt   <= r_cnt - c_LEN_ONE;
        end
    end

    assign gnt      = (w_in_burst && r_first) ? (r_id ? 2'b10 : 2'b01) : 2'b00;
    assign busy     = w_in_burst;
    assign rom_en   = w_in_burst;
    assign rom_addr = w_in_burst ? r_addr : '0;

    // ------------------------------------------------------------------------
    // Return tag pipeline
    // ------------------------------------------------------------------------
    generate
        if (ROM_LAT == 1) begin : g_lat1
            always_ff @(posedge vga_clk) begin
                if (rst) begin
                    r_pv    <= '0;
                    r_pid   <= '0;
                    r_plast <= '0;
                end else begin
                    r_pv    <= w_in_burst;
                    r_pid   <= r_id;
                    r_plast <= w_burst_last;
                end
            end
        end else begin : g_latn
            always_ff @(posedge vga_clk) begin
                if (rst) begin
                    r_pv    <= '0;
                    r_pid   <= '0;
                    r_plast <= '0;
                end else begin
                    r_pv    <= {r_pv[ROM_LAT-2:0],    w_in_burst};
                    r_pid   <= {r_pid[ROM_LAT-2:0],   r_id};
                    r_plast <= {r_plast[ROM_LAT-2:0], w_burst_last};
                end
            end
        end
    endgenerate

    // rd_data passes rom_data straight through on valid cycles and otherwise
    // shows the last word delivered.
    always_ff @(posedge vga_clk) begin
        if (rst) begin
            r_rd_hold <= '0;
        end else if (r_pv[ROM_LAT-1]) begin
            r_rd_hold <= rom_data;
        end
    end

    assign rd_valid = r_pv[ROM_LAT-1] ? (r_pid[ROM_LAT-1] ? 2'b10 : 2'b01) : 2'b00;
    assign rd_last  = r_pv[ROM_LAT-1] & r_plast[ROM_LAT-1];
    assign rd_data  = r_pv[ROM_LAT-1] ? rom_data : r_rd_hold;

endmodule
`default_nettype wire

// File: tb/tb_sprite_rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sprite_rom_arbiter
// Description : Self-checking bench for sprite_rom_arbiter. Two instances share
//               the request inputs, one with ROM latency 1 and one with ROM
//               latency 3; each has its own ROM model whose data encodes the
//               address. A schedule-based reference model predicts every
//               output per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_rom_arbiter;

    localparam int N = 256;   // schedule ring depth in cycles

    logic        clk;
    logic        rst;
    logic [1:0]  req;
    logic [13:0] req_addr0, req_addr1;
    logic [6:0]  req_len0, req_len1;

    logic [1:0]  gnt_a, gnt_b, rd_valid_a, rd_valid_b;
    logic        busy_a, busy_b, rom_en_a, rom_en_b, rd_last_a, rd_last_b;
    logic [13:0] rom_addr_a, rom_addr_b;
    logic [15:0] rom_data_a, rom_data_b, rd_data_a, rd_data_b;

    int nvec = 0;
    int nerr = 0;

    function automatic logic [15:0] romf(input logic [13:0] a);
        return {2'b01, a};
    endfunction

    sprite_rom_arbiter #(.ADDR_W(14), .DATA_W(16), .LEN_W(7), .ROM_LAT(1)) u_dut_l1 (
        .vga_clk(clk), .rst(rst), .req(req),
        .req_addr0(req_addr0), .req_addr1(req_addr1),
        .req_len0(req_len0), .req_len1(req_len1),
        .gnt(gnt_a), .busy(busy_a), .rom_en(rom_en_a), .rom_addr(rom_addr_a),
        .rom_data(rom_data_a), .rd_valid(rd_valid_a), .rd_last(rd_last_a),
        .rd_data(rd_data_a)
    );

    sprite_rom_arbiter #(.ADDR_W(14), .DATA_W(16), .LEN_W(7), .ROM_LAT(3)) u_dut_l3 (
        .vga_clk(clk), .rst(rst), .req(req),
        .req_addr0(req_addr0), .req_addr1(req_addr1),
        .req_len0(req_len0), .req_len1(req_len1),
        .gnt(gnt_b), .busy(busy_b), .rom_en(rom_en_b), .rom_addr(rom_addr_b),
        .rom_data(rom_data_b), .rd_valid(rd_valid_b), .rd_last(rd_last_b),
        .rd_data(rd_data_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM models: data = f(address), delivered 1 and 3 cycles after the read.
    logic [13:0] rq_a;
    logic [13:0] rq_b [3];
    always @(posedge clk) begin
        rq_a    <= rom_addr_a;
        rq_b[0] <= rom_addr_b;
        rq_b[1] <= rq_b[0];
        rq_b[2] <= rq_b[1];
    end
    assign rom_data_a = romf(rq_a);
    assign rom_data_b = romf(rq_b[2]);

    // Observed output bundles; rom_addr only matters while rom_en is high.
    logic [36:0] obs_a, obs_b, exp_a, exp_b;
    assign obs_a = {gnt_a, busy_a, rom_en_a, rom_en_a ? rom_addr_a : 14'd0,
                    rd_valid_a, rd_last_a, rd_data_a};
    assign obs_b = {gnt_b, busy_b, rom_en_b, rom_en_b ? rom_addr_b : 14'd0,
                    rd_valid_b, rd_last_b, rd_data_b};

    // ------------------------------------------------------------------------
    // Reference model: when a burst is granted, its whole timeline (grant,
    // reads, tagged returns for both latencies) is written into per-cycle
    // schedule arrays. Reset wipes everything scheduled from that cycle on.
    // ------------------------------------------------------------------------
    bit [1:0]  s_gnt [N];
    bit        s_en  [N];
    bit [13:0] s_addr[N];
    bit        ra_v[N], ra_id[N], ra_last[N];
    bit [15:0] ra_d[N];
    bit        rb_v[N], rb_id[N], rb_last[N];
    bit [15:0] rb_d[N];
    bit [15:0] hold_a = '0, hold_b = '0;
    int        cyc = 0, free_edge = 0, last_id = 1;
    int        mp, mc, mj, mlen, wid;
    logic [13:0] ma;

    always @(posedge clk) begin
        mp = cyc % N;
        if (ra_v[mp]) hold_a = ra_d[mp];
        if (rb_v[mp]) hold_b = rb_d[mp];
        s_gnt[mp] = '0; s_en[mp] = 0; ra_v[mp] = 0; rb_v[mp] = 0;
        cyc = cyc + 1;
        mc  = cyc % N;
        if (rst) begin
            for (int i = 0; i < 140; i++) begin
                mj = (cyc + i) % N;
                s_gnt[mj] = '0; s_en[mj] = 0; ra_v[mj] = 0; rb_v[mj] = 0;
            end
            hold_a = '0; hold_b = '0;
            last_id = 1;
            free_edge = cyc + 1;
        end else if (cyc >= free_edge && req != 2'b00) begin
            if (req == 2'b11) wid = (last_id == 0) ? 1 : 0;
            else              wid = req[1] ? 1 : 0;
            last_id = wid;
            mlen = (wid == 1) ? int'(req_len1) : int'(req_len0);
            ma   = (wid == 1) ? req_addr1 : req_addr0;
            s_gnt[mc] = (wid == 1) ? 2'b10 : 2'b01;
            for (int k = 0; k <= mlen; k++) begin
                mj = (cyc + k) % N;
                s_en[mj] = 1; s_addr[mj] = ma + 14'(k);
                mj = (cyc + k + 1) % N;
                ra_v[mj] = 1; ra_id[mj] = wid[0]; ra_last[mj] = (k == mlen); ra_d[mj] = romf(ma + 14'(k));
                mj = (cyc + k + 3) % N;
                rb_v[mj] = 1; rb_id[mj] = wid[0]; rb_last[mj] = (k == mlen); rb_d[mj] = romf(ma + 14'(k));
            end
            // last read in cycle cyc+mlen, one idle cycle, then the next grant edge
            free_edge = cyc + mlen + 2;
        end
        exp_a = {s_gnt[mc], s_en[mc], s_en[mc], s_en[mc] ? s_addr[mc] : 14'd0,
                 ra_v[mc] ? (ra_id[mc] ? 2'b10 : 2'b01) : 2'b00, ra_v[mc] & ra_last[mc],
                 ra_v[mc] ? ra_d[mc] : hold_a};
        exp_b = {s_gnt[mc], s_en[mc], s_en[mc], s_en[mc] ? s_addr[mc] : 14'd0,
                 rb_v[mc] ? (rb_id[mc] ? 2'b10 : 2'b01) : 2'b00, rb_v[mc] & rb_last[mc],
                 rb_v[mc] ? rb_d[mc] : hold_b};
    end

    task automatic tick();
        @(negedge clk);
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1; req = 2'b11;
        req_addr0 = 14'($urandom); req_addr1 = 14'($urandom);
        req_len0 = 7'($urandom); req_len1 = 7'($urandom);
        repeat (3) begin
            tick();
            nvec++; if (obs_a !== 37'd0) begin nerr++; $display("FAIL reset_l1 got %h want 0", obs_a); end
            nvec++; if (obs_b !== 37'd0) begin nerr++; $display("FAIL reset_l3 got %h want 0", obs_b); end
            nvec++; if (rom_addr_a !== 14'd0) begin nerr++; $display("FAIL reset_addr got %h want 0", rom_addr_a); end
        end
        rst = 1'b0; req = 2'b00;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_single();
        req = 2'b01; req_addr0 = 14'h0100; req_len0 = 7'd3;
        for (int i = 0; i < 9; i++) begin
            tick();
            nvec++; if (obs_a !== exp_a) begin nerr++; $display("FAIL single_l1 cyc%0d got %h want %h", i, obs_a, exp_a); end
            nvec++; if (obs_b !== exp_b) begin nerr++; $display("FAIL single_l3 cyc%0d got %h want %h", i, obs_b, exp_b); end
            nvec++; if (gnt_a !== ((i == 0) ? 2'b01 : 2'b00)) begin nerr++; $display("FAIL single_gnt cyc%0d got %b", i, gnt_a); end
            nvec++; if (rom_en_a !== (i <= 3) || (i <= 3 && rom_addr_a !== 14'h0100 + 14'(i))) begin
                nerr++; $display("FAIL single_addr cyc%0d got en=%b addr=%h", i, rom_en_a, rom_addr_a); end
            nvec++; if (rd_valid_a !== ((i >= 1 && i <= 4) ? 2'b01 : 2'b00) || rd_last_a !== (i == 4)) begin
                nerr++; $display("FAIL single_ret_l1 cyc%0d got v=%b l=%b", i, rd_valid_a, rd_last_a); end
            nvec++; if (rd_valid_b !== ((i >= 3 && i <= 6) ? 2'b01 : 2'b00) ||
                        (i >= 3 && i <= 6 && rd_data_b !== romf(14'h0100 + 14'(i - 3)))) begin
                nerr++; $display("FAIL single_ret_l3 cyc%0d got v=%b d=%h", i, rd_valid_b, rd_data_b); end
            if (gnt_a[0]) req = 2'b00;
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_both();
        int gcyc[4];
        int gid[4];
        int ng = 0;
        logic [1:0] raise = 2'b00;
        rst = 1'b1; tick(); rst = 1'b0;
        req_addr0 = 14'($urandom); req_addr1 = 14'($urandom);
        req_len0 = 7'($urandom_range(0, 7)); req_len1 = 7'($urandom_range(0, 7));
        req = 2'b11;
        for (int i = 0; i < 60; i++) begin
            tick();
            nvec++; if (obs_a !== exp_a) begin nerr++; $display("FAIL both_l1 cyc%0d got %h want %h", i, obs_a, exp_a); end
            nvec++; if (obs_b !== exp_b) begin nerr++; $display("FAIL both_l3 cyc%0d got %h want %h", i, obs_b, exp_b); end
            if (gnt_a != 2'b00) begin
                if (ng < 4) begin gcyc[ng] = i; gid[ng] = gnt_a[1] ? 1 : 0; ng++; end
                req = req & ~gnt_a;
                raise = (ng < 4) ? gnt_a : 2'b00;
            end else begin
                req = req | raise;
                raise = 2'b00;
                if (ng >= 4) req = 2'b00;
            end
        end
        req = 2'b00;
        nvec++; if (ng != 4) begin nerr++; $display("FAIL both_count got %0d want 4", ng); end
        for (int g = 0; g < ng; g++) begin
            nvec++; if (gid[g] != (g % 2)) begin nerr++; $display("FAIL both_order grant%0d got %0d want %0d", g, gid[g], g % 2); end
        end
        if (ng >= 2) begin
            nvec++; if (gcyc[1] - gcyc[0] != int'(req_len0) + 2) begin
                nerr++; $display("FAIL both_gap got %0d want %0d", gcyc[1] - gcyc[0], int'(req_len0) + 2); end
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_min_len();
        int nbusy = 0, nval = 0, nlast = 0;
        req = 2'b10; req_addr1 = 14'($urandom); req_len1 = 7'd0;
        for (int i = 0; i < 8; i++) begin
            tick();
            nvec++; if (obs_a !== exp_a) begin nerr++; $display("FAIL min_l1 cyc%0d got %h want %h", i, obs_a, exp_a); end
            nvec++; if (obs_b !== exp_b) begin nerr++; $display("FAIL min_l3 cyc%0d got %h want %h", i, obs_b, exp_b); end
            if (busy_a) nbusy++;
            if (rd_valid_a == 2'b10) nval++;
            if (rd_valid_a == 2'b10 && rd_last_a) nlast++;
            if (gnt_a[1]) req = 2'b00;
        end
        nvec++; if (nbusy != 1) begin nerr++; $display("FAIL min_busy got %0d want 1", nbusy); end
        nvec++; if (nval != 1 || nlast != 1) begin nerr++; $display("FAIL min_ret got valid=%0d last=%0d want 1/1", nval, nlast); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_wrap();
        logic [13:0] want[4];
        logic [13:0] seen[4];
        int ns = 0, nv = 0;
        want[0] = 14'h3FFE; want[1] = 14'h3FFF; want[2] = 14'h0000; want[3] = 14'h0001;
        req = 2'b10; req_addr1 = 14'h3FFE; req_len1 = 7'd3;
        for (int i = 0; i < 10; i++) begin
            tick();
            nvec++; if (obs_a !== exp_a) begin nerr++; $display("FAIL wrap_l1 cyc%0d got %h want %h", i, obs_a, exp_a); end
            nvec++; if (obs_b !== exp_b) begin nerr++; $display("FAIL wrap_l3 cyc%0d got %h want %h", i, obs_b, exp_b); end
            if (rom_en_a && ns < 4) begin seen[ns] = rom_addr_a; ns++; end
            if (rd_valid_b == 2'b10) nv++;
            if (gnt_a[1]) req = 2'b00;
        end
        nvec++; if (ns != 4) begin nerr++; $display("FAIL wrap_reads got %0d want 4", ns); end
        for (int k = 0; k < ns; k++) begin
            nvec++; if (seen[k] !== want[k]) begin nerr++; $display("FAIL wrap_addr%0d got %h want %h", k, seen[k], want[k]); end
        end
        nvec++; if (nv != 4) begin nerr++; $display("FAIL wrap_tag got %0d ghost returns want 4", nv); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset_mid();
        int nrd = 0;
        bit hit = 0;
        req = 2'b01; req_addr0 = 14'($urandom); req_len0 = 7'd127;
        for (int i = 0; i < 40 && !hit; i++) begin
            tick();
            nvec++; if (obs_a !== exp_a) begin nerr++; $display("FAIL rstmid_l1 cyc%0d got %h want %h", i, obs_a, exp_a); end
            nvec++; if (obs_b !== exp_b) begin nerr++; $display("FAIL rstmid_l3 cyc%0d got %h want %h", i, obs_b, exp_b); end
            if (gnt_a[0]) req = 2'b00;
            if (rom_en_a) nrd++;
            if (nrd == 10) begin hit = 1; rst = 1'b1; end
        end
        nvec++; if (!hit) begin nerr++; $display("FAIL rstmid_timeout got %0d reads want 10", nrd); end
        tick();
        rst = 1'b0;
        nvec++; if ({rom_en_a, busy_a, rd_valid_a, rd_valid_b} !== 5'b0) begin
            nerr++; $display("FAIL rstmid_abort got en=%b busy=%b v1=%b v3=%b want 0", rom_en_a, busy_a, rd_valid_a, rd_valid_b); end
        for (int i = 0; i < 8; i++) begin
            tick();
            nvec++; if (rd_valid_a !== 2'b00 || rd_valid_b !== 2'b00) begin
                nerr++; $display("FAIL rstmid_flush cyc%0d got v1=%b v3=%b want 00", i, rd_valid_a, rd_valid_b); end
            nvec++; if (obs_b !== exp_b) begin nerr++; $display("FAIL rstmid_post_l3 cyc%0d got %h want %h", i, obs_b, exp_b); end
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_random();
        for (int i = 0; i < 2000; i++) begin
            tick();
            nvec++; if (obs_a !== exp_a) begin nerr++; $display("FAIL rand_l1 cyc%0d got %h want %h", i, obs_a, exp_a); end
            nvec++; if (obs_b !== exp_b) begin nerr++; $display("FAIL rand_l3 cyc%0d got %h want %h", i, obs_b, exp_b); end
            for (int b = 0; b < 2; b++) begin
                if (gnt_a[b]) begin
                    req[b] = 1'b0;
                end else if (!req[b]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        req[b] = 1'b1;
                        if (b == 0) begin
                            req_addr0 = 14'($urandom);
                            req_len0  = ($urandom_range(0, 9) == 0) ? 7'($urandom) : 7'($urandom_range(0, 7));
                        end else begin
                            req_addr1 = 14'($urandom);
                            req_len1  = ($urandom_range(0, 9) == 0) ? 7'($urandom) : 7'($urandom_range(0, 7));
                        end
                    end
                end else if ($urandom_range(0, 29) == 0) begin
                    req[b] = 1'b0;   // request withdrawn before grant
                end
            end
            rst = ($urandom_range(0, 299) == 0);
        end
        rst = 1'b0; req = 2'b00;
    endtask

    initial begin
        rst = 1'b1; req = 2'b00;
        req_addr0 = '0; req_addr1 = '0; req_len0 = '0; req_len1 = '0;
        test_reset();
        test_single();
        test_both();
        test_min_len();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire
